// File: rtl/seq_player_pkg.sv
// Shared definitions for the sequence player: FSM state encoding and
// default sizing/timing constants used by the RTL and the testbench.
// The optional abort input is enabled with SEQ_PLAYER_ABORT_EN.
package seq_player_pkg;

    // Explicit encodings so every user of the package agrees on the values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SEQ_SIZE  = 4;
    localparam int DEF_T_ON  = 25_000_000;
    localparam int DEF_T_OFF = 12_500_000;
    localparam int DEF_CNT_W = 26;

endpackage

// File: rtl/seq_player_if.sv
// Player-side bundle: game controller handshake, ROM address/colour and LEDs.
// abortar exists only when SEQ_PLAYER_ABORT_EN is defined.
interface seq_player_if #(
    parameter int SIZE = 4
);
    logic            start;
    logic [SIZE-1:0] nivel;
    logic [SIZE-1:0] cor_rom;
    logic [SIZE-1:0] address;
    logic [SIZE-1:0] leds;
    logic            ocupado;
    logic            fim;
`ifdef SEQ_PLAYER_ABORT_EN
    logic            abortar;
`endif

    // Controller / ROM / LED side.
    modport master (
        output start, nivel, cor_rom,
`ifdef SEQ_PLAYER_ABORT_EN
        output abortar,
`endif
        input  address, leds, ocupado, fim
    );

    // Player side.
    modport slave (
        input  start, nivel, cor_rom,
`ifdef SEQ_PLAYER_ABORT_EN
        input  abortar,
`endif
        output address, leds, ocupado, fim
    );
endinterface

// File: rtl/seq_player_timer.sv
// seq_timer: up-counter with synchronous clear and terminal-count compare.
// tc is high while the count equals lim; the owner clears on tc to restart.
module seq_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] lim,
    output logic             tc
);
    logic [CNT_W-1:0] count;

    // Count up while enabled; clear has priority over counting.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == lim);
endmodule

// File: rtl/seq_player.sv
// seq_player: shows steps 0..nivel of the colour sequence on the LEDs,
// T_ON cycles lit then T_OFF cycles blank per step, then pulses fim.
// Optional feature: define SEQ_PLAYER_ABORT_EN to add the abortar input.
module seq_player
    import seq_player_pkg::*;
#(
    parameter int SIZE  = SEQ_SIZE,
    parameter int T_ON  = DEF_T_ON,
    parameter int T_OFF = DEF_T_OFF,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    seq_player_if.slave  bus
);
    localparam logic [CNT_W-1:0] LIM_ON  = CNT_W'(T_ON - 1);
    localparam logic [CNT_W-1:0] LIM_OFF = CNT_W'(T_OFF - 1);

    state_t            state;
    logic [SIZE-1:0]   address;
    logic [SIZE-1:0]   nivel_q;
    logic              ocupado;
    logic              fim;
    logic              abort_hit;
    logic              timer_clr;
    logic              timer_en;
    logic [CNT_W-1:0]  timer_lim;
    logic              tc;

`ifdef SEQ_PLAYER_ABORT_EN
    assign abort_hit = bus.abortar && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Timer control: run in SHOW/GAP, restart on terminal count, idle at zero.
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    always_comb begin
        timer_en  = 1'b0;
        timer_clr = 1'b1;
        timer_lim = LIM_OFF;
        case (state)
            SHOW: begin
                timer_en  = 1'b1;
                timer_clr = tc;
                timer_lim = LIM_ON;
            end
            GAP: begin
                timer_en  = 1'b1;
                timer_clr = tc;
            end
            default: ;
        endcase
        if (abort_hit) begin
            timer_clr = 1'b1;
        end
    end

    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .lim (timer_lim),
        .tc  (tc)
    );

    // Playback FSM with registered address, busy flag and end pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            address <= '0;
            nivel_q <= '0;
            ocupado <= 1'b0;
            fim     <= 1'b0;
        end else if (abort_hit) begin
            state   <= IDLE;
            address <= '0;
            ocupado <= 1'b0;
            fim     <= 1'b0;
        end else begin
            fim <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        nivel_q <= bus.nivel;
                        address <= '0;
                        ocupado <= 1'b1;
                        state   <= SHOW;
                    end
                end
                SHOW: begin
                    if (tc) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tc) begin
                        // Last step shown: finish without touching the address,
                        // so nivel = max never wraps it.
                        if (address == nivel_q) begin
                            fim   <= 1'b1;
                            state <= DONE;
                        end else begin
                            address <= address + 1'b1;
                            state   <= SHOW;
                        end
                    end
                end
                DONE: begin
                    address <= '0;
                    ocupado <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.address = address;
    assign bus.leds    = (state == SHOW) ? bus.cor_rom : '0;
    assign bus.ocupado = ocupado;
    assign bus.fim     = fim;
endmodule

// File: tb/tb_seq_player.sv
// Directed testbench for seq_player with T_ON=4, T_OFF=2 and a ROM model
// returning 1 << (address % 4). Define SEQ_PLAYER_ABORT_EN to also cover abortar.
module tb_seq_player;
    import seq_player_pkg::*;

    localparam int SZ    = SEQ_SIZE;
    localparam int TON   = 4;
    localparam int TOFF  = 2;
    localparam int STEP  = TON + TOFF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seq_player_if #(.SIZE(SZ)) bus ();

    seq_player #(
        .SIZE  (SZ),
        .T_ON  (TON),
        .T_OFF (TOFF),
        .CNT_W (DEF_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational sequence ROM model.
    logic [1:0] rom_idx;
    assign rom_idx     = bus.address[1:0];
    assign bus.cor_rom = 4'b0001 << rom_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] a, input logic [3:0] l,
                             input logic o, input logic f);
        check({tag, ".address"}, 32'(bus.address), 32'(a));
        check({tag, ".leds"},    32'(bus.leds),    32'(l));
        check({tag, ".ocupado"}, 32'(bus.ocupado), 32'(o));
        check({tag, ".fim"},     32'(bus.fim),     32'(f));
    endtask

    // Start a run of nv+1 steps and check every output each cycle up to two
    // cycles past fim. With disturb set, start is re-pulsed and nivel changed
    // during step 0, and start is raised in the DONE cycle.
    task automatic run_play(input string tag, input int nv, input bit disturb);
        int         fim_c;
        int         step;
        int         phase;
        logic [3:0] ea;
        logic [3:0] el;
        logic       eo;
        logic       ef;
        fim_c     = (nv + 1) * STEP + 1;
        bus.nivel = 4'(nv);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= fim_c + 2; c++) begin
            if (c > 1) tick();
            step  = (c - 1) / STEP;
            phase = (c - 1) % STEP;
            if (c < fim_c) begin
                ea = 4'(step);
                el = (phase < TON) ? (4'b0001 << (step % 4)) : 4'b0000;
                eo = 1'b1;
                ef = 1'b0;
            end else if (c == fim_c) begin
                ea = 4'(nv);
                el = 4'b0000;
                eo = 1'b1;
                ef = 1'b1;
            end else begin
                ea = 4'b0000;
                el = 4'b0000;
                eo = 1'b0;
                ef = 1'b0;
            end
            check_out($sformatf("%s.c%0d", tag, c), ea, el, eo, ef);
            if (disturb) begin
                if (c == 2) begin
                    bus.start = 1'b1;
                    bus.nivel = 4'd0;
                end else if (c == 3) begin
                    bus.start = 1'b0;
                end else if (c == fim_c) begin
                    bus.start = 1'b1;
                end else if (c == fim_c + 1) begin
                    bus.start = 1'b0;
                end
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.nivel = 4'd0;
`ifdef SEQ_PLAYER_ABORT_EN
        bus.abortar = 1'b0;
`endif

        // 1: reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("reset.c%0d", i), 4'd0, 4'd0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        tick();

        // 2-4: single step, four steps, full sixteen steps.
        run_play("nivel0", 0, 1'b0);
        run_play("nivel3", 3, 1'b0);
        run_play("nivel15", 15, 1'b0);

        // 5: start re-pulsed / nivel changed mid-play, start in DONE ignored.
        run_play("disturb", 3, 1'b1);

        // 6: reset during SHOW of step 2 (cycle 7).
        bus.nivel = 4'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        check_out("rst_mid.pre", 4'd1, 4'b0010, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check_out("rst_mid.edge", 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_out($sformatf("rst_mid.after%0d", c), 4'd0, 4'd0, 1'b0, 1'b0);
        end

        // Reset wins over start.
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        check_out("rst_vs_start", 4'd0, 4'd0, 1'b0, 1'b0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        check_out("rst_vs_start.after", 4'd0, 4'd0, 1'b0, 1'b0);

`ifdef SEQ_PLAYER_ABORT_EN
        // Abort during GAP of step 1 (cycle 5).
        bus.nivel = 4'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 2; c <= 5; c++) tick();
        check_out("abort.pre", 4'd0, 4'd0, 1'b1, 1'b0);
        bus.abortar = 1'b1;
        tick();
        check_out("abort.edge", 4'd0, 4'd0, 1'b0, 1'b0);
        bus.abortar = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_out($sformatf("abort.after%0d", c), 4'd0, 4'd0, 1'b0, 1'b0);
        end
        // A fresh run after abort plays normally.
        run_play("post_abort", 1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
